// File: rtl/opendap_apb_test_slave.sv
// APB3 test completer for the Mem-AP downstream bus: ID register, scratch RAM,
// transfer counter, and bus-programmable wait-state / error-response injection.
module opendap_apb_test_slave #(
    parameter logic [31:0] ID_VALUE   = 32'h0da9_7e57,
    parameter int unsigned RAM_WORDS  = 64,
    parameter logic [7:0]  RESET_WAIT = 8'h00
) (
    input  logic        swclk,
    input  logic        rst_n_por,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr
);

    localparam int unsigned IDX_W     = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam logic [6:0]  RAM_LIMIT = 7'(RAM_WORDS);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [7:0]  wait_cfg_q, wait_cfg_d;
    logic        force_once_q, force_once_d;
    logic        err_ram_wr_q, err_ram_wr_d;
    logic [15:0] access_count_q, access_count_d;
    logic [31:0] last_addr_q, last_addr_d;
    logic [31:0] ram_q [RAM_WORDS];

    logic             sel_id, sel_wait, sel_err, sel_count, sel_last, sel_ram;
    logic [5:0]       ram_idx;
    logic [IDX_W-1:0] ram_ptr;
    logic             ram_oor;
    logic [31:0]      ram_rdata;
    logic [31:0]      read_data;
    logic             xfer_err;
    logic             complete;
    logic             wr_commit;
    logic             ram_we;

    // Decode from the low 12 address bits only, so the map aliases every 4 KiB.
    always_comb begin
        sel_id    = (paddr[11:2] == 10'h000);
        sel_wait  = (paddr[11:2] == 10'h001);
        sel_err   = (paddr[11:2] == 10'h002);
        sel_count = (paddr[11:2] == 10'h003);
        sel_last  = (paddr[11:2] == 10'h004);
        sel_ram   = (paddr[11:8] == 4'h1);
        ram_idx   = paddr[7:2];
        ram_ptr   = ram_idx[IDX_W-1:0];
        ram_oor   = sel_ram && ({1'b0, ram_idx} >= RAM_LIMIT);
    end

    always_comb begin
        ram_rdata = '0;
        if (!ram_oor) begin
            ram_rdata = ram_q[ram_ptr];
        end
    end

    always_comb begin
        read_data = paddr;
        if (sel_id) begin
            read_data = ID_VALUE;
        end else if (sel_wait) begin
            read_data = {24'd0, wait_cfg_q};
        end else if (sel_err) begin
            read_data = {30'd0, err_ram_wr_q, force_once_q};
        end else if (sel_count) begin
            read_data = {16'd0, access_count_q};
        end else if (sel_last) begin
            read_data = last_addr_q;
        end else if (sel_ram) begin
            read_data = ram_rdata;
        end
    end

    // Error sources listed in priority order; all of them merely set pslverr.
    always_comb begin
        xfer_err = 1'b0;
        if (force_once_q) begin
            xfer_err = 1'b1;
        end else if (paddr[1:0] != 2'b00) begin
            xfer_err = 1'b1;
        end else if (ram_oor) begin
            xfer_err = 1'b1;
        end else if (sel_ram && pwrite && err_ram_wr_q) begin
            xfer_err = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        complete   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    state_d    = ACCESS;
                    wait_cnt_d = wait_cfg_q;
                end
            end
            ACCESS: begin
                if (!psel) begin
                    state_d = IDLE;
                end else if (penable) begin
                    if (wait_cnt_q != 8'd0) begin
                        wait_cnt_d = wait_cnt_q - 8'd1;
                    end else begin
                        complete = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pready  = complete;
        pslverr = complete && xfer_err;
        prdata  = '0;
        if (complete && !pwrite && !xfer_err) begin
            prdata = read_data;
        end
    end

    // Counter bump and FORCE_ONCE clear come first so a same-cycle write overrides them.
    always_comb begin
        wait_cfg_d     = wait_cfg_q;
        force_once_d   = force_once_q;
        err_ram_wr_d   = err_ram_wr_q;
        access_count_d = access_count_q;
        last_addr_d    = last_addr_q;
        wr_commit      = complete && pwrite && !xfer_err;
        ram_we         = wr_commit && sel_ram;
        if (complete) begin
            access_count_d = access_count_q + 16'd1;
            last_addr_d    = paddr;
            force_once_d   = 1'b0;
        end
        if (wr_commit) begin
            if (sel_wait) begin
                wait_cfg_d = pwdata[7:0];
            end
            if (sel_err) begin
                force_once_d = pwdata[0];
                err_ram_wr_d = pwdata[1];
            end
            if (sel_count) begin
                access_count_d = '0;
            end
        end
    end

    always_ff @(posedge swclk or negedge rst_n_por) begin
        if (!rst_n_por) begin
            state_q        <= IDLE;
            wait_cnt_q     <= '0;
            wait_cfg_q     <= RESET_WAIT;
            force_once_q   <= 1'b0;
            err_ram_wr_q   <= 1'b0;
            access_count_q <= '0;
            last_addr_q    <= '0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            wait_cfg_q     <= wait_cfg_d;
            force_once_q   <= force_once_d;
            err_ram_wr_q   <= err_ram_wr_d;
            access_count_q <= access_count_d;
            last_addr_q    <= last_addr_d;
        end
    end

    always_ff @(posedge swclk) begin
        if (ram_we) begin
            ram_q[ram_ptr] <= pwdata;
        end
    end

endmodule

// File: tb/tb_opendap_apb_test_slave.sv
// Bench for opendap_apb_test_slave: directed vector table, protocol corner
// sequences, and random transfers checked against a map-level reference model.
module tb_opendap_apb_test_slave;

    localparam int          RW      = 32;
    localparam logic [31:0] ID      = 32'h0da9_7e57;
    localparam logic [7:0]  RST_WT  = 8'h00;

    logic        swclk = 1'b0;
    logic        rst_n_por;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [31:0] prdata;
    logic        pready, pslverr;

    int n_chk  = 0;
    int n_fail = 0;

    opendap_apb_test_slave #(
        .ID_VALUE  (ID),
        .RAM_WORDS (RW),
        .RESET_WAIT(RST_WT)
    ) dut (
        .swclk    (swclk),
        .rst_n_por(rst_n_por),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr)
    );

    always #5 swclk = ~swclk;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model state: the register map as the bus sees it.
    logic [7:0]  m_wait;
    bit          m_force, m_ramwr;
    logic [15:0] m_cnt;
    logic [31:0] m_last;
    logic [31:0] m_ram  [64];
    bit          m_ramv [64];

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          err;
        int          waits;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rdata, input bit err, input int waits);
        vec_t r;
        r.wr = wr; r.addr = addr; r.wdata = wdata; r.rdata = rdata; r.err = err; r.waits = waits;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_wait  = RST_WT;
        m_force = 1'b0;
        m_ramwr = 1'b0;
        m_cnt   = '0;
        m_last  = '0;
        for (int i = 0; i < 64; i++) m_ramv[i] = 1'b0;
    endtask

    task automatic model_xfer(input bit wr, input logic [31:0] a, input logic [31:0] d,
                              output logic [31:0] erd, output bit eerr, output int ewaits,
                              output bit known);
        int  off;
        int  idx;
        bit  is_ram;
        off    = int'(a & 32'h0000_0fff);
        is_ram = (off >= 256) && (off < 512);
        idx    = is_ram ? (off - 256) / 4 : 0;
        ewaits = int'(m_wait);
        eerr   = m_force || (off % 4 != 0) || (is_ram && idx >= RW) || (is_ram && wr && m_ramwr);
        erd    = '0;
        known  = 1'b1;
        if (!wr && !eerr) begin
            if (off == 0)       erd = ID;
            else if (off == 4)  erd = {24'd0, m_wait};
            else if (off == 8)  erd = {30'd0, m_ramwr, m_force};
            else if (off == 12) erd = {16'd0, m_cnt};
            else if (off == 16) erd = m_last;
            else if (is_ram) begin
                if (m_ramv[idx]) erd = m_ram[idx];
                else known = 1'b0;
            end else erd = a;
        end
        m_cnt   = m_cnt + 16'd1;
        m_last  = a;
        m_force = 1'b0;
        if (wr && !eerr) begin
            if (off == 4)  m_wait = d[7:0];
            if (off == 8) begin
                m_force = d[0];
                m_ramwr = d[1];
            end
            if (off == 12) m_cnt = '0;
            if (is_ram) begin
                m_ram[idx]  = d;
                m_ramv[idx] = 1'b1;
            end
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the completion edge so a
    // following call produces a back-to-back setup cycle.
    task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output bit err, output int waits, output bit to);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(negedge swclk);
        chk("setup_quiet", {31'd0, pready}, 32'd0);
        @(posedge swclk); #1;
        penable = 1'b1;
        waits = 0; to = 1'b1; rd = '0; err = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge swclk);
            if (pready) begin
                rd = prdata; err = pslverr; to = 1'b0;
                break;
            end
            chk("wait_quiet", {prdata[31:1], prdata[0] | pslverr}, 32'd0);
            waits++;
            @(posedge swclk); #1;
        end
        @(posedge swclk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic run(input bit wr, input logic [31:0] a, input logic [31:0] d, input string nm);
        logic [31:0] erd, rd;
        bit eerr, known, err, to;
        int ewaits, waits;
        model_xfer(wr, a, d, erd, eerr, ewaits, known);
        xfer(wr, a, d, rd, err, waits, to);
        chk({nm, "_timeout"}, {31'd0, to}, 32'd0);
        chk({nm, "_waits"}, waits, ewaits);
        chk({nm, "_err"}, {31'd0, err}, {31'd0, eerr});
        if (known) chk({nm, "_data"}, rd, erd);
    endtask

    task automatic idle_cycle();
        @(posedge swclk); #1;
    endtask

    initial begin
        logic [31:0] rd, a, d, r;
        bit err, to, known_u, eerr_u;
        int waits, ewaits_u;
        logic [31:0] erd_u;

        rst_n_por = 1'b0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        model_reset();

        tbl.push_back(v(0, 32'h000, 32'h0, ID,           0, 0));
        tbl.push_back(v(0, 32'h00C, 32'h0, 32'h1,        0, 0));
        tbl.push_back(v(1, 32'h100, 32'hcafef00d, 32'h0, 0, 0));
        tbl.push_back(v(1, 32'h17C, 32'h12345678, 32'h0, 0, 0));
        tbl.push_back(v(0, 32'h100, 32'h0, 32'hcafef00d, 0, 0));
        tbl.push_back(v(0, 32'h17C, 32'h0, 32'h12345678, 0, 0));
        tbl.push_back(v(0, 32'h180, 32'h0, 32'h0,        1, 0));
        tbl.push_back(v(1, 32'h1FC, 32'h0, 32'h0,        1, 0));
        tbl.push_back(v(1, 32'h004, 32'h3, 32'h0,        0, 0));
        tbl.push_back(v(0, 32'h004, 32'h0, 32'h3,        0, 3));
        tbl.push_back(v(1, 32'h004, 32'h0, 32'h0,        0, 3));
        tbl.push_back(v(0, 32'h004, 32'h0, 32'h0,        0, 0));
        tbl.push_back(v(1, 32'h104, 32'h11111111, 32'h0, 0, 0));
        tbl.push_back(v(1, 32'h008, 32'h1, 32'h0,        0, 0));
        tbl.push_back(v(1, 32'h104, 32'hffffffff, 32'h0, 1, 0));
        tbl.push_back(v(0, 32'h104, 32'h0, 32'h11111111, 0, 0));
        tbl.push_back(v(0, 32'h008, 32'h0, 32'h0,        0, 0));
        tbl.push_back(v(0, 32'h102, 32'h0, 32'h0,        1, 0));
        tbl.push_back(v(0, 32'hABC, 32'h0, 32'h00000abc, 0, 0));
        tbl.push_back(v(0, 32'h00010ABC, 32'h0, 32'h00010abc, 0, 0));
        tbl.push_back(v(0, 32'h010, 32'h0, 32'h00010abc, 0, 0));
        tbl.push_back(v(1, 32'h008, 32'h2, 32'h0,        0, 0));
        tbl.push_back(v(1, 32'h108, 32'h5, 32'h0,        1, 0));
        tbl.push_back(v(0, 32'h008, 32'h0, 32'h2,        0, 0));
        tbl.push_back(v(0, 32'h00001100, 32'h0, 32'hcafef00d, 0, 0));
        tbl.push_back(v(1, 32'h008, 32'h0, 32'h0,        0, 0));
        tbl.push_back(v(1, 32'h000, 32'hdeadbeef, 32'h0, 0, 0));
        tbl.push_back(v(0, 32'h000, 32'h0, ID,           0, 0));
        tbl.push_back(v(1, 32'hABC, 32'h1, 32'h0,        0, 0));
        tbl.push_back(v(1, 32'h00C, 32'h1234, 32'h0,     0, 0));
        tbl.push_back(v(0, 32'h00C, 32'h0, 32'h0,        0, 0));
        tbl.push_back(v(0, 32'h00C, 32'h0, 32'h1,        0, 0));
        tbl.push_back(v(0, 32'h001, 32'h0, 32'h0,        1, 0));

        repeat (2) @(posedge swclk);
        @(negedge swclk);
        chk("reset_pready", {31'd0, pready}, 32'd0);
        chk("reset_pslverr", {31'd0, pslverr}, 32'd0);
        chk("reset_prdata", prdata, 32'd0);
        @(posedge swclk); #1;
        rst_n_por = 1'b1;

        foreach (tbl[i]) begin
            model_xfer(tbl[i].wr, tbl[i].addr, tbl[i].wdata, erd_u, eerr_u, ewaits_u, known_u);
            xfer(tbl[i].wr, tbl[i].addr, tbl[i].wdata, rd, err, waits, to);
            chk($sformatf("vec%0d_timeout", i), {31'd0, to}, 32'd0);
            chk($sformatf("vec%0d_data", i), rd, tbl[i].rdata);
            chk($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, tbl[i].err});
            chk($sformatf("vec%0d_waits", i), waits, tbl[i].waits);
        end

        // Abort: psel dropped mid-wait must not commit or count.
        idle_cycle();
        run(1, 32'h004, 32'h5, "abort_cfg");
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h000;
        @(posedge swclk); #1;
        penable = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge swclk);
            chk("abort_wait_ready", {31'd0, pready}, 32'd0);
            @(posedge swclk); #1;
        end
        psel = 1'b0; penable = 1'b0;
        @(negedge swclk);
        chk("abort_idle_ready", {31'd0, pready}, 32'd0);
        @(posedge swclk); #1;
        run(0, 32'h00C, 32'h0, "abort_count");
        run(1, 32'h004, 32'h0, "wait_clear");

        // penable without a setup cycle is ignored.
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h00C; pwdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge swclk);
            chk("nosetup_ready", {31'd0, pready}, 32'd0);
            @(posedge swclk); #1;
        end
        psel = 1'b0; penable = 1'b0;
        idle_cycle();
        run(0, 32'h00C, 32'h0, "nosetup_count");

        // Randomised traffic against the model, zero to two idle cycles between transfers.
        for (int n = 0; n < 300; n++) begin
            a = $urandom;
            r = $urandom;
            case ($urandom_range(0, 6))
                0: a = 32'($urandom_range(0, 4)) * 4;
                1, 2: a = 32'h100 + 32'($urandom_range(0, 40)) * 4;
                3: a = a & 32'h0000_01ff;
                4: a = (a & 32'hffff_f000) | (32'h200 + (r % 32'hE00)) & 32'hffff_fffc;
                5: a = (a & 32'hffff_f000) | (32'h100 + 32'($urandom_range(0, 31)) * 4);
                default: a = (a & 32'hffff_f000) | (32'($urandom_range(0, 4)) * 4);
            endcase
            d = $urandom;
            if ((a & 32'hfff) == 32'h004) d = d & 32'hffff_ff03;
            run(1'($urandom_range(0, 1)), a, d, "rand");
            repeat ($urandom_range(0, 2)) idle_cycle();
        end

        // Reset asserted during a wait: outputs drop, WAIT_CFG returns to its reset value.
        run(1, 32'h008, 32'h0, "pre_rst_err");
        run(1, 32'h004, 32'h5, "pre_rst_cfg");
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h000;
        @(posedge swclk); #1;
        penable = 1'b1;
        repeat (2) @(posedge swclk);
        #3;
        rst_n_por = 1'b0;
        #1;
        chk("rst_wait_ready", {31'd0, pready}, 32'd0);
        psel = 1'b0; penable = 1'b0;
        @(posedge swclk); #1;
        rst_n_por = 1'b1;
        model_reset();
        run(0, 32'h004, 32'h0, "rst_wait_cfg");

        // Reset asserted in the completion cycle: pready drops asynchronously, no commit.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h000;
        @(posedge swclk); #1;
        penable = 1'b1;
        @(negedge swclk);
        chk("rst_cpl_ready_before", {31'd0, pready}, 32'd1);
        chk("rst_cpl_data_before", prdata, ID);
        #1;
        rst_n_por = 1'b0;
        #1;
        chk("rst_cpl_ready_after", {31'd0, pready}, 32'd0);
        chk("rst_cpl_data_after", prdata, 32'd0);
        psel = 1'b0; penable = 1'b0;
        @(posedge swclk); #1;
        rst_n_por = 1'b1;
        model_reset();
        run(0, 32'h00C, 32'h0, "rst_cpl_count");
        run(0, 32'h010, 32'h0, "rst_cpl_last");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
